square_period_meter: RTL and testbench



---
 rtl/square_period_meter.sv | 131 +++++++++++++
 tb/tb_square_period_meter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/square_period_meter.sv
// ---------------------------------------------------------------------------
// square_period_meter
//
// Purpose:
//   Measures a square wave carried on an unsigned DATA_W-bit sample stream.
//   Each qualified sample is sliced to a logic level with hysteresis:
//     - at or above HI_THR the level goes high
//     - at or below LO_THR the level goes low
//     - in between, the level is held
//   The block then counts the period and the high time, in qualified samples,
//   between successive rising edges of that level. It reports one result per
//   complete cycle.
//
// Ports:
//   clk        system clock, rising-edge
//   rst_n      synchronous active-low reset
//   sig_in     unsigned sample (midscale = 2**(DATA_W-1))
//   sample_en  qualifies sig_in; no state advances while low
//   period_out last measured period, in samples
//   high_out   last measured high time, in samples
//   valid      one-cycle strobe, high when period_out/high_out were just updated
//   locked     high while measuring (a rise was seen, no timeout since)
//   timeout    sticky period-overflow flag, cleared by the next valid
// ---------------------------------------------------------------------------
module square_period_meter #(
  parameter int                 DATA_W     = 12,
  parameter int                 CNT_W      = 24,
  parameter logic [DATA_W-1:0]  HI_THR     = DATA_W'(2560),
  parameter logic [DATA_W-1:0]  LO_THR     = DATA_W'(1536),
  parameter logic [CNT_W-1:0]   MAX_PERIOD = CNT_W'(24'hFFFFFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sig_in,
  input  logic              sample_en,
  output logic [CNT_W-1:0]  period_out,
  output logic [CNT_W-1:0]  high_out,
  output logic              valid,
  output logic              locked,
  output logic              timeout
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The overflow check looks one count ahead.
  // As a result, the period reported on a rise (cnt+1) can never exceed MAX_PERIOD.
  localparam logic [CNT_W-1:0] CNT_LAST = MAX_PERIOD - CNT_ONE;

  state_t             state;
  logic               level;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   high_cnt;

  logic               rise;
  logic               fall;

  // Edge detection against the current sliced level.
  // Samples between the two thresholds produce neither edge, which gives the hysteresis.
  assign rise = sample_en && !level && (sig_in >= HI_THR);
  assign fall = sample_en &&  level && (sig_in <= LO_THR);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      level      <= 1'b0;
      cnt        <= '0;
      high_cnt   <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (sample_en) begin
        if (rise) begin
          level <= 1'b1;
        end else if (fall) begin
          level <= 1'b0;
        end

        case (state)
          IDLE: begin
            // The first rise only establishes the phase reference.
            // No result can be reported yet.
            if (rise) begin
              state    <= MEASURE;
              cnt      <= '0;
              high_cnt <= CNT_ONE;
              locked   <= 1'b1;
            end
          end

          MEASURE: begin
            if (rise) begin
              // The rising sample itself closes the period.
              // It is also the first high sample of the next period.
              period_out <= cnt + CNT_ONE;
              high_out   <= high_cnt;
              valid      <= 1'b1;
              timeout    <= 1'b0;
              cnt        <= '0;
              high_cnt   <= CNT_ONE;
            end else if (cnt == CNT_LAST) begin
              // Give up on this period.
              // The level is kept, so re-locking needs a genuine low-to-high transition.
              state   <= IDLE;
              timeout <= 1'b1;
              locked  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
              if (level && !fall) begin
                high_cnt <= high_cnt + CNT_ONE;
              end
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_square_period_meter.sv
// ---------------------------------------------------------------------------
// tb_square_period_meter
//
// Directed testbench for square_period_meter, instantiated with MAX_PERIOD=16
// so that the overflow path can be reached quickly.
//
// Stimulus tasks push the hand-computed result of every rise that should close
// a period into a queue. A monitor on the falling clock edge pops one entry
// per valid strobe and compares it.
// ---------------------------------------------------------------------------
module tb_square_period_meter;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 24;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] sig_in;
  logic              sample_en;
  logic [CNT_W-1:0]  period_out;
  logic [CNT_W-1:0]  high_out;
  logic              valid;
  logic              locked;
  logic              timeout;

  typedef struct {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;

  square_period_meter #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .HI_THR    (12'd2560),
    .LO_THR    (12'd1536),
    .MAX_PERIOD(24'd16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .sample_en (sample_en),
    .period_out(period_out),
    .high_out  (high_out),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (valid) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cycle;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("period_out", 32'(period_out), 32'(e.period));
        checkOutput("high_out",   32'(high_out),   32'(e.high));
        checkOutput("timeout_on_valid", 32'(timeout), 32'd0);
      end
    end
  end

  // Drives one clock's worth of inputs.
  // Outputs are then visible 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] s, input logic en);
    sig_in    = s;
    sample_en = en;
    @(posedge clk);
    #1;
  endtask

  // One qualified sample.
  // In slow mode it is followed by a disabled clock carrying the opposite
  // extreme value, which would create edges if sample_en were ignored.
  task automatic sendSample(input logic [DATA_W-1:0] s, input bit slow);
    applyStimulus(s, 1'b1);
    if (slow) applyStimulus((s >= 12'd2048) ? 12'd0 : 12'd4095, 1'b0);
  endtask

  task automatic applyPeriod(input int hi_n, input int lo_n, input bit slow,
                             input bit push, input int ep, input int eh);
    if (push) exp_q.push_back('{period: CNT_W'(ep), high: CNT_W'(eh)});
    for (int i = 0; i < hi_n; i++) sendSample(12'd4095, slow);
    for (int i = 0; i < lo_n; i++) sendSample(12'd0, slow);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(12'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_period"},  32'(period_out), 32'd0);
    checkOutput({tag, "_high"},    32'(high_out),   32'd0);
    checkOutput({tag, "_valid"},   32'(valid),      32'd0);
    checkOutput({tag, "_locked"},  32'(locked),     32'd0);
    checkOutput({tag, "_timeout"}, 32'(timeout),    32'd0);
  endtask

  logic [DATA_W-1:0] hyst [8] = '{12'd3000, 12'd3000, 12'd3000, 12'd1000,
                                  12'd2200, 12'd1800, 12'd1000, 12'd1000};

  initial begin
    rst_n     = 1'b0;
    sig_in    = '0;
    sample_en = 1'b0;
    repeat (2) applyStimulus(12'd0, 1'b0);
    doReset();
    checkAllZero("reset");

    // 1: 4 high / 4 low at full rate
    $display("[TB] test 1: basic 50%% duty wave");
    applyStimulus(12'd4095, 1'b1);
    checkOutput("t1_locked_first_rise", 32'(locked), 32'd1);
    checkOutput("t1_no_valid_first_rise", 32'(valid), 32'd0);
    for (int i = 0; i < 3; i++) sendSample(12'd4095, 1'b0);
    for (int i = 0; i < 4; i++) sendSample(12'd0, 1'b0);
    for (int p = 0; p < 3; p++) applyPeriod(4, 4, 1'b0, 1'b1, 8, 4);
    exp_q.push_back('{period: 24'd8, high: 24'd4});
    sendSample(12'd4095, 1'b0);

    // 2: same wave, every other clock enabled
    $display("[TB] test 2: sample_en every other clock");
    doReset();
    applyPeriod(4, 4, 1'b1, 1'b0, 0, 0);
    applyPeriod(4, 4, 1'b1, 1'b1, 8, 4);
    applyPeriod(4, 4, 1'b1, 1'b1, 8, 4);
    exp_q.push_back('{period: 24'd8, high: 24'd4});
    sendSample(12'd4095, 1'b1);
    checkOutput("t2_valid_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd16);

    // 3: samples between the thresholds must not create edges
    $display("[TB] test 3: hysteresis");
    doReset();
    for (int p = 0; p < 3; p++) begin
      if (p > 0) exp_q.push_back('{period: 24'd8, high: 24'd3});
      for (int i = 0; i < 8; i++) sendSample(hyst[i], 1'b0);
    end
    exp_q.push_back('{period: 24'd8, high: 24'd3});
    sendSample(12'd3000, 1'b0);

    // 4: timeout with MAX_PERIOD=16, then re-lock
    $display("[TB] test 4: timeout and re-lock");
    doReset();
    applyPeriod(4, 4, 1'b0, 1'b0, 0, 0);
    applyPeriod(4, 4, 1'b0, 1'b1, 8, 4);
    exp_q.push_back('{period: 24'd8, high: 24'd4});
    sendSample(12'd4095, 1'b0);
    for (int i = 0; i < 15; i++) sendSample(12'd4095, 1'b0);
    checkOutput("t4_no_timeout_yet", 32'(timeout), 32'd0);
    checkOutput("t4_still_locked", 32'(locked), 32'd1);
    sendSample(12'd4095, 1'b0);
    checkOutput("t4_timeout_set", 32'(timeout), 32'd1);
    checkOutput("t4_unlocked", 32'(locked), 32'd0);
    checkOutput("t4_period_held", 32'(period_out), 32'd8);
    checkOutput("t4_high_held", 32'(high_out), 32'd4);
    for (int i = 0; i < 4; i++) sendSample(12'd0, 1'b0);
    checkOutput("t4_timeout_sticky", 32'(timeout), 32'd1);
    applyStimulus(12'd4095, 1'b1);
    checkOutput("t4_relocked", 32'(locked), 32'd1);
    checkOutput("t4_timeout_until_valid", 32'(timeout), 32'd1);
    for (int i = 0; i < 3; i++) sendSample(12'd4095, 1'b0);
    for (int i = 0; i < 4; i++) sendSample(12'd0, 1'b0);
    exp_q.push_back('{period: 24'd8, high: 24'd4});
    sendSample(12'd4095, 1'b0);
    checkOutput("t4_timeout_cleared", 32'(timeout), 32'd0);

    // 5: reset in the middle of a high phase
    $display("[TB] test 5: reset mid-measurement");
    doReset();
    applyPeriod(4, 4, 1'b0, 1'b0, 0, 0);
    applyPeriod(3, 0, 1'b0, 1'b1, 8, 4);
    doReset();
    checkAllZero("t5_reset");
    applyPeriod(4, 4, 1'b0, 1'b0, 0, 0);
    checkOutput("t5_no_valid_after_relock", 32'(period_out), 32'd0);
    exp_q.push_back('{period: 24'd8, high: 24'd4});
    sendSample(12'd4095, 1'b0);

    // 6: 1 high / 9 low
    $display("[TB] test 6: asymmetric duty");
    doReset();
    applyPeriod(1, 9, 1'b0, 1'b0, 0, 0);
    applyPeriod(1, 9, 1'b0, 1'b1, 10, 1);
    exp_q.push_back('{period: 24'd10, high: 24'd1});
    sendSample(12'd4095, 1'b0);

    repeat (4) applyStimulus(12'd0, 1'b0);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
